// File: rtl/nmos_bus_arbiter.sv
// Round-robin owner sequencing for a shared nmos pass-transistor bus, with a break-before-make dead gap.
// Optional forced release after MAX_HOLD drive cycles when NMOS_BUS_ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// S_IDLE  | no owner, all gates off, waiting for any request
// S_DRIVE | one gate on, owner drives the bus until it drops req
// S_TURN  | all gates off for DEAD_CYC cycles before the next owner
module nmos_bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int DEAD_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data_in,
    output logic [N-1:0]         gate_en,
    output wire  [W-1:0]         bus_out,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_L = (IW+1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

    if (N < 2 || N > 16 || DEAD_CYC < 1 || DEAD_CYC > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("nmos_bus_arbiter: parameter out of range");
    end

    state_t          state, state_nxt;
    logic [N-1:0]    gate_nxt;
    logic [IW-1:0]   owner_nxt, ptr, ptr_nxt, winner;
    logic [3:0]      dead, dead_nxt;
    logic [IW:0]     cand, wplus;
    logic            found, take, rel;
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
    logic [7:0]      hold, hold_nxt;
    logic            tmo_nxt;
`endif

    // Rotating priority search: first set req at or after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= N_L) cand = cand - N_L;
            if (!found && req[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
        wplus = {1'b0, winner} + (IW+1)'(1);
        if (wplus == N_L) wplus = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gate_en <= '0;
            owner   <= '0;
            ptr     <= '0;
            dead    <= '0;
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
            hold    <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            gate_en <= gate_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            dead    <= dead_nxt;
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
            hold    <= hold_nxt;
            timeout <= tmo_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        gate_nxt  = gate_en;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        dead_nxt  = dead;
        take      = 1'b0;
        rel       = 1'b0;
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
        hold_nxt  = hold;
        tmo_nxt   = 1'b0;
`endif
        case (state)
            S_IDLE: take = found;
            S_DRIVE: begin
                rel = !req[owner];
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
                if (hold != 8'(MAX_HOLD)) hold_nxt = hold + 8'd1;
                if (req[owner] && hold == 8'(MAX_HOLD)) begin
                    rel     = 1'b1;
                    tmo_nxt = 1'b1;
                end
`endif
                if (rel) begin
                    state_nxt = S_TURN;
                    gate_nxt  = '0;
                    dead_nxt  = 4'(DEAD_CYC - 1);
                end
            end
            S_TURN: begin
                if (dead == 4'd0) begin
                    take = found;
                    if (!found) state_nxt = S_IDLE;
                end else begin
                    dead_nxt = dead - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (take) begin
            state_nxt = S_DRIVE;
            gate_nxt  = N'(1) << winner;
            owner_nxt = winner;
            ptr_nxt   = wplus[IW-1:0];
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
            hold_nxt  = 8'd1;
`endif
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

`ifndef NMOS_BUS_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    // Each source bit reaches the shared net only through its own pass switch.
    for (genvar i = 0; i < N; i++) begin : g_src
        for (genvar b = 0; b < W; b++) begin : g_bit
            nmos u_sw (bus_out[b], data_in[i*W+b], gate_en[i]);
        end
    end
endmodule

// File: tb/tb_nmos_bus_arbiter.sv
// Directed bench for nmos_bus_arbiter: default instance (DEAD_CYC=1) plus a DEAD_CYC=3 instance.
// Timeout expectations follow NMOS_BUS_ARB_TIMEOUT_EN.
module tb_nmos_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  gate_en;
    wire  [7:0]  bus_out;
    logic [1:0]  owner;
    logic        busy, timeout;

    logic [3:0]  req3 = '0;
    logic [31:0] data3 = '0;
    logic [3:0]  gate3;
    wire  [7:0]  bus3;
    logic [1:0]  owner3;
    logic        busy3, timeout3;

    int n_chk = 0;
    int n_pass = 0;

    nmos_bus_arbiter #(.N(4), .W(8), .DEAD_CYC(1), .MAX_HOLD(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gate_en(gate_en),
        .bus_out(bus_out), .owner(owner), .busy(busy), .timeout(timeout)
    );

    nmos_bus_arbiter #(.N(4), .W(8), .DEAD_CYC(3), .MAX_HOLD(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .data_in(data3), .gate_en(gate3),
        .bus_out(bus3), .owner(owner3), .busy(busy3), .timeout(timeout3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] onehot;
        int         exp_o;
        data_in = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
        #12 rst_n = 1'b1;
        chk("rst_gate", 32'(gate_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_tmo", 32'(timeout), 32'h0);
        step();
        chk("idle_gate", 32'(gate_en), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // single grant, release, dead gap, back to idle
        req = 4'b0100;
        step();
        chk("g2_gate", 32'(gate_en), 32'h4);
        chk("g2_owner", 32'(owner), 32'h2);
        chk("g2_bus", 32'(bus_out), 32'hA5);
        chk("g2_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        chk("turn_gate", 32'(gate_en), 32'h0);
        chk("turn_busy", 32'(busy), 32'h1);
        step();
        chk("idle2_gate", 32'(gate_en), 32'h0);
        chk("idle2_busy", 32'(busy), 32'h0);

        // asynchronous reset while driving
        req = 4'b0001;
        step();
        chk("pre_rst_gate", 32'(gate_en), 32'h1);
        chk("pre_rst_bus", 32'(bus_out), 32'hC0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gate", 32'(gate_en), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        req = 4'b0000;
        #1 rst_n = 1'b1;

        // all requesting, each owner releases after 2 cycles then re-raises
        step();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_o = g % 4;
            step();
            chk("rr_gate", 32'(gate_en), 32'(1) << exp_o);
            chk("rr_owner", 32'(owner), 32'(exp_o));
            step();
            chk("rr_hold", 32'(gate_en), 32'(1) << exp_o);
            req[exp_o] = 1'b0;
            step();
            chk("rr_dead", 32'(gate_en), 32'h0);
            req[exp_o] = 1'b1;
        end
        req = 4'b0000;
        step();
        chk("rr_end_busy", 32'(busy), 32'h0);

        // DEAD_CYC=3: non-owner request ignored, three dead cycles, direct handover
        req3 = 4'b0010;
        step();
        chk("d3_grant", 32'(gate3), 32'h2);
        req3 = 4'b1010;
        step();
        chk("d3_nopreempt", 32'(gate3), 32'h2);
        req3 = 4'b1000;
        for (int d = 0; d < 3; d++) begin
            step();
            chk("d3_dead", 32'(gate3), 32'h0);
            chk("d3_busy", 32'(busy3), 32'h1);
        end
        step();
        chk("d3_next_gate", 32'(gate3), 32'h8);
        chk("d3_next_owner", 32'(owner3), 32'h3);
        req3 = 4'b0000;

        // two complementary drivers under random requests
        data_in = {8'h00, 8'h00, 8'h00, 8'hFF};
        for (int c = 0; c < 200; c++) begin
            req = {2'b00, 2'($urandom_range(0, 3))};
            step();
            onehot = gate_en;
            chk("rnd_onehot", 32'($countones(onehot) <= 1), 32'h1);
            if (onehot != 4'b0000) begin
                chk("rnd_bus", 32'(bus_out), onehot[0] ? 32'hFF : 32'h00);
                chk("rnd_known", 32'($isunknown(bus_out)), 32'h0);
            end
        end

        // long hold by owner 0 with owner 1 waiting
        req = 4'b0000;
        repeat (3) step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 4'b0011;
        step();
        chk("hold_first", 32'(gate_en), 32'h1);
`ifdef NMOS_BUS_ARB_TIMEOUT_EN
        for (int c = 2; c <= 16; c++) begin
            step();
            chk("hold_drive", 32'(gate_en), 32'h1);
            chk("hold_no_tmo", 32'(timeout), 32'h0);
        end
        step();
        chk("tmo_gate", 32'(gate_en), 32'h0);
        chk("tmo_pulse", 32'(timeout), 32'h1);
        step();
        chk("tmo_owner", 32'(owner), 32'h1);
        chk("tmo_gate1", 32'(gate_en), 32'h2);
        chk("tmo_low", 32'(timeout), 32'h0);
`else
        for (int c = 2; c <= 40; c++) begin
            step();
            chk("hold_drive", 32'(gate_en), 32'h1);
            chk("hold_no_tmo", 32'(timeout), 32'h0);
        end
        chk("hold_owner", 32'(owner), 32'h0);
`endif
        req = 4'b0000;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nmos_bus_arbiter.md
Name: nmos_bus_arbiter

Overview:
- Round-robin arbiter that shares one W-bit pass-transistor bus between N requesters.
- Each requester's data reaches the bus only through per-bit nmos switches. The arbiter sequences the switch gates: at most one source connected, with a break-before-make dead gap between owners.
- Sits between requester blocks and the shared net. bus_out floats (Z) whenever no gate is on.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, bus width in bits
- DEAD_CYC, 1, dead cycles with all gates off between owners (1..15)
- MAX_HOLD, 16, maximum consecutive DRIVE cycles per grant; used only with the optional feature (1..255)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  N  level request; held high while the requester wants the bus; dropping it releases the bus
- data_in  input  N*W  requester data, slice i = data_in[i*W +: W]
- gate_en  output  N  registered nmos gate enables, one-hot or zero
- bus_out  output  W  wire; the OR of nmos(bus_out[b], data_in[i*W+b], gate_en[i]) for all i, b
- owner  output  clog2(N)  index of the current or last owner
- busy  output  1  high in DRIVE and TURN
- timeout  output  1  one-cycle pulse on forced release (optional feature only, else tied 0)

Behaviour:
- Reset values (async on rst_n low): state=IDLE, gate_en=0, owner=0, busy=0, timeout=0, rr pointer=0, dead counter=0. bus_out is therefore Z.
- Reset mid-DRIVE drops gate_en to 0 immediately, not at a clock edge.
- Arbitration:
  - Round-robin search starts at index ptr and runs ptr, ptr+1, ... mod N; first set req wins.
  - On grant, ptr <= winner+1 mod N.
- States:
  - IDLE: if any req, go to DRIVE next edge. gate_en[winner]=1, owner=winner, busy=1, hold counter=1. Latency is 1 cycle from req sampled high to gate_en high.
  - DRIVE: while req[owner]=1, stay. gate_en is unchanged and the hold counter saturates.
  - DRIVE to TURN: when req[owner]=0 is sampled, go to TURN next edge with gate_en=0 and dead counter=DEAD_CYC-1. The new owner is never enabled on the same edge the old one turns off.
  - Requests from non-owners during DRIVE are ignored. No preemption.
  - TURN: all gates off, busy=1. When the dead counter reaches 0, arbitrate on the current req: a winner goes straight to DRIVE (no IDLE cycle); otherwise go to IDLE with busy=0.
  - TURN length is exactly DEAD_CYC cycles of gate_en=0.
- req re-assert by the previous owner during TURN is legal. It competes normally, but its ptr position gives it lowest priority.
- Simultaneous requests in IDLE: the lowest index at or after ptr wins.
- Invariant: popcount(gate_en) <= 1 at all times; no X on gate_en after reset.
- Data is not registered: bus_out follows data_in[owner] combinationally while gated.

Optional Feature:
- Macro NMOS_BUS_ARB_TIMEOUT_EN.
- Defined:
  - In DRIVE, when the hold counter reaches MAX_HOLD with req[owner] still 1, force the DRIVE to TURN transition.
  - timeout pulses high for 1 cycle, coincident with the first TURN cycle.
  - The owner keeps req high but is arbitrated afresh, with lowest priority.
- Undefined: no hold counter logic, timeout tied to 0, an owner may hold indefinitely.

Test Plan (N=4, W=8, DEAD_CYC=1, MAX_HOLD=16 unless stated):
- Reset then idle, req=0 -> gate_en=4'b0000, bus_out=8'hzz, busy=0; assert rst_n low during DRIVE -> gate_en=0 with no clock edge.
- req=4'b0100, data_in slice 2=8'hA5 -> next cycle gate_en=4'b0100, owner=2, bus_out=8'hA5; drop req -> gate_en=0 for exactly 1 cycle, then IDLE, busy=0.
- req=4'b1111 held, each owner drops req after 2 cycles then re-raises -> grant order 0,1,2,3,0; exactly one all-zero gate_en cycle between consecutive grants.
- DEAD_CYC=3, owner 1 releases while req[3]=1 -> 3 cycles of gate_en=0, then gate_en=4'b1000 directly.
- Two drivers, 8'hFF and 8'h00, continuous random req -> bus_out never X and popcount(gate_en)<=1 on every cycle.
- NMOS_BUS_ARB_TIMEOUT_EN, req[0] held 40 cycles with req[1]=1 -> forced release after 16 DRIVE cycles, timeout pulse, owner=1 after TURN. Without the macro, owner 0 holds all 40 cycles.
